// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution layer sequencer and its load block.
package conv_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DIM_W_DEF  = 8;
    localparam int CNT_W_DEF  = 8;
    localparam int LEN_W_DEF  = 16;

    localparam logic LD_SEL_IMG = 1'b0;
    localparam logic LD_SEL_FLT = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        LD_IMG,
        WT_IMG,
        LD_FLT,
        WT_FLT,
        CONV,
        WT_CONV,
        STORE,
        WT_STORE,
        FIN
    } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Channel/filter counters and incrementally stepped image, kernel and output addresses.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              next_chan,
    input  logic              next_filt,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] flt_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [CNT_W-1:0]  img_count,
    input  logic [CNT_W-1:0]  flt_count,
    input  logic [LEN_W-1:0]  img_len,
    input  logic [LEN_W-1:0]  flt_len,
    input  logic [LEN_W-1:0]  out_len,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] flt_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  chan_idx,
    output logic              last_chan,
    output logic              last_filt
);

    logic [CNT_W-1:0]  filt_idx;
    logic [ADDR_W-1:0] img_base_q;
    logic [ADDR_W-1:0] img_step;
    logic [ADDR_W-1:0] flt_step;
    logic [ADDR_W-1:0] out_step;

    // Lengths are word strides; addresses wrap silently modulo 2^ADDR_W.
    assign img_step = ADDR_W'(img_len);
    assign flt_step = ADDR_W'(flt_len);
    assign out_step = ADDR_W'(out_len);

    assign last_chan = (chan_idx == img_count - CNT_W'(1));
    assign last_filt = (filt_idx == flt_count - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            chan_idx   <= '0;
            filt_idx   <= '0;
            img_addr   <= '0;
            flt_addr   <= '0;
            out_addr   <= '0;
            img_base_q <= '0;
        end else if (init) begin
            chan_idx   <= '0;
            filt_idx   <= '0;
            img_base_q <= img_base;
            img_addr   <= img_base;
            flt_addr   <= flt_base;
            out_addr   <= out_base;
        end else if (next_chan) begin
            chan_idx <= chan_idx + CNT_W'(1);
            img_addr <= img_addr + img_step;
            flt_addr <= flt_addr + flt_step;
        end else if (next_filt) begin
            // Kernels are filter-major, so the kernel pointer keeps marching on.
            filt_idx <= filt_idx + CNT_W'(1);
            chan_idx <= '0;
            img_addr <= img_base_q;
            flt_addr <= flt_addr + flt_step;
            out_addr <= out_addr + out_step;
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Control sequencer for one convolution layer: load image/kernel, run engine, store map.
// Optional cycle counter output perf_cycles is enabled by defining CONV_SEQ_PERF_EN.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  img_count,
    input  logic [DIM_W-1:0]  img_size,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [CNT_W-1:0]  flt_count,
    input  logic [DIM_W-1:0]  flt_size,
    input  logic [ADDR_W-1:0] flt_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ld_req,
    input  logic              ld_ready,
    output logic              ld_sel,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [LEN_W-1:0]  ld_len,
    input  logic              ld_done,
    output logic              conv_start,
    output logic              conv_acc,
    input  logic              conv_done,
    output logic              st_req,
    input  logic              st_ready,
    output logic [ADDR_W-1:0] st_addr,
    output logic [LEN_W-1:0]  st_len,
    input  logic              st_done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    state_t state, state_next;

    logic [CNT_W-1:0]   img_count_q, flt_count_q;
    logic [LEN_W-1:0]   img_len_q, flt_len_q, out_len_q;
    logic [2*DIM_W-1:0] img_sq, flt_sq, out_sq;
    logic [DIM_W-1:0]   out_side;
    logic               cfg_empty, cfg_bad;
    logic               accept, next_chan, next_filt;

    logic [ADDR_W-1:0]  img_addr, flt_addr, out_addr;
    logic [CNT_W-1:0]   chan_idx;
    logic               last_chan, last_filt;

    // out_side is only meaningful when 0 < K <= N; otherwise the run is rejected.
    assign img_sq    = img_size * img_size;
    assign flt_sq    = flt_size * flt_size;
    assign out_side  = img_size - flt_size + DIM_W'(1);
    assign out_sq    = out_side * out_side;
    assign cfg_empty = (img_count == '0) || (flt_count == '0);
    assign cfg_bad   = (flt_size == '0) || (flt_size > img_size);

    assign busy = (state != IDLE) && (state != FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            img_count_q <= '0;
            flt_count_q <= '0;
            img_len_q   <= '0;
            flt_len_q   <= '0;
            out_len_q   <= '0;
            err         <= 1'b0;
        end else if (accept) begin
            img_count_q <= img_count;
            flt_count_q <= flt_count;
            img_len_q   <= LEN_W'(img_sq);
            flt_len_q   <= LEN_W'(flt_sq);
            out_len_q   <= LEN_W'(out_sq);
            err         <= cfg_bad && !cfg_empty;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        next_chan  = 1'b0;
        next_filt  = 1'b0;
        done       = 1'b0;
        ld_req     = 1'b0;
        ld_sel     = LD_SEL_IMG;
        ld_addr    = '0;
        ld_len     = '0;
        conv_start = 1'b0;
        conv_acc   = 1'b0;
        st_req     = 1'b0;
        st_addr    = '0;
        st_len     = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (cfg_empty || cfg_bad) state_next = FIN;
                    else                      state_next = LD_IMG;
                end
            end
            LD_IMG: begin
                ld_req  = 1'b1;
                ld_sel  = LD_SEL_IMG;
                ld_addr = img_addr;
                ld_len  = img_len_q;
                if (ld_ready) state_next = WT_IMG;
            end
            WT_IMG: begin
                if (ld_done) state_next = LD_FLT;
            end
            LD_FLT: begin
                ld_req  = 1'b1;
                ld_sel  = LD_SEL_FLT;
                ld_addr = flt_addr;
                ld_len  = flt_len_q;
                if (ld_ready) state_next = WT_FLT;
            end
            WT_FLT: begin
                if (ld_done) state_next = CONV;
            end
            CONV: begin
                conv_start = 1'b1;
                conv_acc   = (chan_idx != '0);
                state_next = WT_CONV;
            end
            WT_CONV: begin
                if (conv_done) begin
                    if (last_chan) begin
                        state_next = STORE;
                    end else begin
                        next_chan  = 1'b1;
                        state_next = LD_IMG;
                    end
                end
            end
            STORE: begin
                st_req  = 1'b1;
                st_addr = out_addr;
                st_len  = out_len_q;
                if (st_ready) state_next = WT_STORE;
            end
            WT_STORE: begin
                if (st_done) begin
                    if (last_filt) begin
                        state_next = FIN;
                    end else begin
                        next_filt  = 1'b1;
                        state_next = LD_IMG;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    conv_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .init      (accept),
        .next_chan (next_chan),
        .next_filt (next_filt),
        .img_base  (img_base),
        .flt_base  (flt_base),
        .out_base  (out_base),
        .img_count (img_count_q),
        .flt_count (flt_count_q),
        .img_len   (img_len_q),
        .flt_len   (flt_len_q),
        .out_len   (out_len_q),
        .img_addr  (img_addr),
        .flt_addr  (flt_addr),
        .out_addr  (out_addr),
        .chan_idx  (chan_idx),
        .last_chan (last_chan),
        .last_filt (last_filt)
    );

`ifdef CONV_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with responder models and an expected-transaction scoreboard.
module tb_conv_layer_sequencer;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 8;
    localparam int CNT_W  = 8;
    localparam int LEN_W  = 16;

    localparam int IMG_BASE = 'h100;
    localparam int FLT_BASE = 'h200;
    localparam int OUT_BASE = 'h300;

    typedef struct {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } ld_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } st_t;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [CNT_W-1:0]  img_count, flt_count;
    logic [DIM_W-1:0]  img_size, flt_size;
    logic [ADDR_W-1:0] img_base, flt_base, out_base;
    logic              busy, done, err;
    logic              ld_req, ld_ready, ld_sel, ld_done;
    logic [ADDR_W-1:0] ld_addr;
    logic [LEN_W-1:0]  ld_len;
    logic              conv_start, conv_acc, conv_done;
    logic              st_req, st_ready, st_done;
    logic [ADDR_W-1:0] st_addr;
    logic [LEN_W-1:0]  st_len;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    ld_t ld_q[$];
    bit  conv_q[$];
    st_t st_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    int ld_hs      = 0;
    int ld_stall   = 0;
    int stall_cnt  = 0;
    bit busy_seen  = 0;
    bit conv_hold  = 0;
    bit ld_pend    = 0;
    bit conv_pend  = 0;
    bit st_pend    = 0;

    always #5 clk = ~clk;

    conv_layer_sequencer #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .CNT_W  (CNT_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .img_count  (img_count),
        .img_size   (img_size),
        .img_base   (img_base),
        .flt_count  (flt_count),
        .flt_size   (flt_size),
        .flt_base   (flt_base),
        .out_base   (out_base),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ld_req     (ld_req),
        .ld_ready   (ld_ready),
        .ld_sel     (ld_sel),
        .ld_addr    (ld_addr),
        .ld_len     (ld_len),
        .ld_done    (ld_done),
        .conv_start (conv_start),
        .conv_acc   (conv_acc),
        .conv_done  (conv_done),
        .st_req     (st_req),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_len     (st_len),
        .st_done    (st_done)
`ifdef CONV_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: compare every request cycle against the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (ld_req) begin
                if (ld_q.size() == 0) begin
                    check("ld_unexpected", ld_req, 1'b0);
                end else begin
                    check("ld_sel", ld_sel, ld_q[0].sel);
                    check("ld_addr", ld_addr, ld_q[0].addr);
                    check("ld_len", ld_len, ld_q[0].len);
                    if (ld_ready) void'(ld_q.pop_front());
                end
                if (ld_ready) begin
                    ld_hs++;
                    ld_pend = 1'b1;
                end
            end
            if (conv_start) begin
                if (conv_q.size() == 0) check("conv_unexpected", conv_start, 1'b0);
                else check("conv_acc", conv_acc, conv_q.pop_front());
                conv_pend = 1'b1;
            end
            if (st_req) begin
                if (st_q.size() == 0) begin
                    check("st_unexpected", st_req, 1'b0);
                end else begin
                    check("st_addr", st_addr, st_q[0].addr);
                    check("st_len", st_len, st_q[0].len);
                    if (st_ready) void'(st_q.pop_front());
                end
                if (st_ready) st_pend = 1'b1;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 1'b0);
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    // Responders: drive handshakes and completion pulses just after each edge.
    always @(posedge clk) begin
        #1;
        ld_done = ld_pend;
        ld_pend = 1'b0;
        conv_done = conv_pend && !conv_hold;
        if (!conv_hold) conv_pend = 1'b0;
        st_done = st_pend;
        st_pend = 1'b0;
        if (ld_req) begin
            if (stall_cnt >= ld_stall) begin
                ld_ready = 1'b1;
            end else begin
                ld_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            ld_ready  = 1'b0;
            stall_cnt = 0;
        end
        st_ready = st_req;
    end

    // Expected transactions, computed by direct multiplication rather than stepping.
    task automatic push_expected(input int c, input int f, input int n, input int k);
        ld_t e;
        st_t s;
        int  m;
        m = n - k + 1;
        for (int fi = 0; fi < f; fi++) begin
            for (int ci = 0; ci < c; ci++) begin
                e.sel  = 1'b0;
                e.addr = ADDR_W'(IMG_BASE + ci * n * n);
                e.len  = LEN_W'(n * n);
                ld_q.push_back(e);
                e.sel  = 1'b1;
                e.addr = ADDR_W'(FLT_BASE + (fi * c + ci) * k * k);
                e.len  = LEN_W'(k * k);
                ld_q.push_back(e);
                conv_q.push_back(ci != 0);
            end
            s.addr = ADDR_W'(OUT_BASE + fi * m * m);
            s.len  = LEN_W'(m * m);
            st_q.push_back(s);
        end
    endtask

    task automatic apply_config(input int c, input int f, input int n, input int k);
        img_count = CNT_W'(c);
        flt_count = CNT_W'(f);
        img_size  = DIM_W'(n);
        flt_size  = DIM_W'(k);
        img_base  = ADDR_W'(IMG_BASE);
        flt_base  = ADDR_W'(FLT_BASE);
        out_base  = ADDR_W'(OUT_BASE);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // Configuration must already be captured; disturb it to prove that.
        img_size = DIM_W'($urandom);
        flt_size = DIM_W'($urandom);
        img_base = ADDR_W'($urandom);
        flt_base = ADDR_W'($urandom);
        out_base = ADDR_W'($urandom);
        img_count = CNT_W'($urandom);
        flt_count = CNT_W'($urandom);
    endtask

    task automatic run_layer(input int c, input int f, input int n, input int k,
                             input bit exp_err, input int stall);
        bit runs;
        int cycles;
        runs = (c != 0) && (f != 0) && (k != 0) && (k <= n);
        ld_stall  = stall;
        done_cnt  = 0;
        ld_hs     = 0;
        busy_seen = 1'b0;
        apply_config(c, f, n, k);
        if (runs) push_expected(c, f, n, k);
        pulse_start();
        @(negedge clk);
        if (runs) check("busy_rise", busy, 1'b1);
        else      check("done_early", done, 1'b1);
        cycles = 0;
        while (done_cnt == 0 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", done_cnt != 0, 1'b1);
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("err", err, exp_err);
        check("busy_idle", busy, 1'b0);
        check("busy_seen", busy_seen, runs);
        check("ld_handshakes", ld_hs, runs ? 2 * c * f : 0);
        check("ld_q_left", ld_q.size(), 0);
        check("conv_q_left", conv_q.size(), 0);
        check("st_q_left", st_q.size(), 0);
        ld_q.delete();
        conv_q.delete();
        st_q.delete();
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_ld_req"}, ld_req, 1'b0);
        check({tag, "_ld_sel"}, ld_sel, 1'b0);
        check({tag, "_ld_addr"}, ld_addr, '0);
        check({tag, "_ld_len"}, ld_len, '0);
        check({tag, "_conv_start"}, conv_start, 1'b0);
        check({tag, "_conv_acc"}, conv_acc, 1'b0);
        check({tag, "_st_req"}, st_req, 1'b0);
        check({tag, "_st_addr"}, st_addr, '0);
        check({tag, "_st_len"}, st_len, '0);
    endtask

    initial begin
        int cycles;
        reset     = 1'b1;
        start     = 1'b0;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        conv_done = 1'b0;
        st_ready  = 1'b0;
        st_done   = 1'b0;
        apply_config(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_idle("reset");
        #1 reset = 1'b0;

        // Two channels, one filter: clear then accumulate, one store.
        run_layer(2, 1, 4, 3, 1'b0, 0);
        // One channel, three filters: image base reloads, kernel and output step.
        run_layer(1, 3, 5, 2, 1'b0, 0);
        // Load block stalls five cycles on every request.
        run_layer(1, 1, 4, 3, 1'b0, 5);
        // Kernel larger than image.
        run_layer(1, 1, 4, 6, 1'b1, 0);
        // Zero channels: nothing issued, error cleared by this start.
        run_layer(0, 1, 4, 3, 1'b0, 0);
        // Kernel of size zero is also rejected.
        run_layer(2, 2, 4, 0, 1'b1, 0);
        // Zero filters.
        run_layer(3, 0, 4, 3, 1'b0, 0);

        // Abort from WT_CONV with reset, then rerun from scratch.
        conv_hold = 1'b1;
        done_cnt  = 0;
        ld_stall  = 0;
        apply_config(2, 1, 4, 3);
        push_expected(2, 1, 4, 3);
        pulse_start();
        cycles = 0;
        while (conv_q.size() != 1 && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        check("abort_reached_conv", conv_q.size(), 1);
        repeat (2) @(negedge clk);
        check("abort_waiting", busy, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_idle("abort");
        #1 reset = 1'b0;
        conv_hold = 1'b0;
        conv_pend = 1'b0;
        ld_q.delete();
        conv_q.delete();
        st_q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 1'b0);
        run_layer(2, 1, 4, 3, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
